// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU result stage.
// Legal opcodes are numbered D0..D10 in ascending encoding order.
package alu_pkg;

    localparam logic [3:0] OP_D0  = 4'b0000;
    localparam logic [3:0] OP_D1  = 4'b0001;
    localparam logic [3:0] OP_D2  = 4'b0011;
    localparam logic [3:0] OP_D3  = 4'b1000;
    localparam logic [3:0] OP_D4  = 4'b1001;
    localparam logic [3:0] OP_D5  = 4'b1010;
    localparam logic [3:0] OP_D6  = 4'b1011;
    localparam logic [3:0] OP_D7  = 4'b1100;
    localparam logic [3:0] OP_D8  = 4'b1101;
    localparam logic [3:0] OP_D9  = 4'b1110;
    localparam logic [3:0] OP_D10 = 4'b1111;

    typedef struct packed {
        logic [7:0] result;
        logic [3:0] op;
        logic       zero;
        logic       neg;
        logic       parity;
        logic       illegal;
    } result_entry_t;

    localparam int ENTRY_W = $bits(result_entry_t);

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_D0, OP_D1, OP_D2, OP_D3,
            OP_D4, OP_D5, OP_D6, OP_D7,
            OP_D8, OP_D9, OP_D10: legal = 1'b1;
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Producer/consumer handshake bundle of the ALU result stage.
// The stage itself connects through the slave modport.
interface alu_result_stage_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [3:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic       out_parity;
    logic       out_illegal;

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op,
        input  out_zero, out_neg, out_parity, out_illegal
    );

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op,
        output out_zero, out_neg, out_parity, out_illegal
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Generic DEPTH x W register FIFO with count-based full/empty.
// The head is read straight from the storage registers.
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    // A push never lands on the head slot while it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag generation, illegal masking,
// result buffering and accepted/illegal statistics.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    alu_result_stage_if.slave bus,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [7:0]       ill_cnt
);

    result_entry_t wr_entry;
    result_entry_t rd_entry;
    logic          legal;
    logic [7:0]    masked;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign legal  = is_legal_op(bus.in_op);
    assign masked = legal ? bus.in_result : 8'h00;

    always_comb begin
        wr_entry         = '0;
        wr_entry.result  = masked;
        wr_entry.op      = bus.in_op;
        wr_entry.zero    = ~|masked;
        wr_entry.neg     = masked[7];
        wr_entry.parity  = ^masked;
        wr_entry.illegal = ~legal;
    end

    assign bus.in_ready  = ~full | clear;
    assign bus.out_valid = ~empty;
    assign push = bus.in_valid & ~full & ~clear;
    assign pop  = bus.out_valid & bus.out_ready & ~clear;

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_result  = rd_entry.result;
    assign bus.out_op      = rd_entry.op;
    assign bus.out_zero    = rd_entry.zero;
    assign bus.out_neg     = rd_entry.neg;
    assign bus.out_parity  = rd_entry.parity;
    assign bus.out_illegal = rd_entry.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            ill_cnt <= '0;
        end else if (clear) begin
            acc_cnt <= '0;
            ill_cnt <= '0;
        end else if (push) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (!legal && ill_cnt != 8'hFF) ill_cnt <= ill_cnt + 8'd1;
        end
    end

endmodule
